// File: rtl/cva6_lsu_model_pkg.sv
// Shared types for the LSU ordering model: queue entry states, the address tag
// and the pointer width helper used by both queues.
package cva6_lsu_model_pkg;

    localparam int ADDR_HI_DEF = 11;
    localparam int ADDR_LO_DEF = 3;

    typedef enum logic [1:0] {
        SQ_FREE        = 2'd0,
        SQ_COMMITTED   = 2'd1,
        SQ_UNCOMMITTED = 2'd3
    } sq_state_e;

    typedef enum logic [1:0] {
        LQ_FREE    = 2'd0,
        LQ_ISSUE   = 2'd1,
        LQ_DONE    = 2'd2,
        LQ_BLOCKED = 2'd3
    } lq_state_e;

    typedef logic [ADDR_HI_DEF-ADDR_LO_DEF:0] tag_t;

    // A single-entry queue still needs a 1-bit pointer to stay a legal vector.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cva6_lsu_lq.sv
// In-order load queue: per-load store dependency masks, BLOCKED/ISSUE/DONE
// progression, and a full squash on flush.
module cva6_lsu_lq
    import cva6_lsu_model_pkg::*;
#(
    parameter int LQ_DEPTH = 2,
    parameter int SQ_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  alloc_i,
    input  logic [SQ_DEPTH-1:0]   new_dep_i,
    input  logic [SQ_DEPTH-1:0]   freed_sq_i,
    input  logic                  resp_i,
    input  logic                  flush_i,
    output lq_state_e             head_state_o,
    output logic [2*LQ_DEPTH-1:0] state_o
);

    localparam int PW = ptr_w(LQ_DEPTH);

    lq_state_e           state_q [LQ_DEPTH];
    lq_state_e           state_d [LQ_DEPTH];
    logic [SQ_DEPTH-1:0] dep_q   [LQ_DEPTH];
    logic [SQ_DEPTH-1:0] dep_d   [LQ_DEPTH];
    logic [PW-1:0]       head_q, head_d;
    logic [PW-1:0]       tail_q, tail_d;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(LQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A blocked load only wakes once its registered mask is already empty,
    // so a store freed this cycle releases its dependants one cycle later.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            dep_d[i] = dep_q[i] & ~freed_sq_i;
            if (state_q[i] == LQ_BLOCKED && dep_q[i] == '0) begin
                state_d[i] = LQ_ISSUE;
            end
        end
        if (state_q[head_q] == LQ_DONE) begin
            state_d[head_q] = LQ_FREE;
            head_d          = inc(head_q);
        end else if (resp_i && state_q[head_q] == LQ_ISSUE) begin
            state_d[head_q] = LQ_DONE;
        end
        if (alloc_i) begin
            state_d[tail_q] = (new_dep_i != '0) ? LQ_BLOCKED : LQ_ISSUE;
            dep_d[tail_q]   = new_dep_i;
            tail_d          = inc(tail_q);
        end
        if (flush_i) begin
            for (int i = 0; i < LQ_DEPTH; i++) begin
                state_d[i] = LQ_FREE;
                dep_d[i]   = '0;
            end
            head_d = '0;
            tail_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LQ_DEPTH; i++) begin
                state_q[i] <= LQ_FREE;
                dep_q[i]   <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
        end else begin
            for (int i = 0; i < LQ_DEPTH; i++) begin
                state_q[i] <= state_d[i];
                dep_q[i]   <= dep_d[i];
            end
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_comb begin
        state_o = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            state_o[2*i +: 2] = state_q[i];
        end
    end

    assign head_state_o = state_q[head_q];

endmodule

// File: rtl/cva6_lsu_model_mq.sv
// Reference LSU ordering model: registered input stage, store queue with
// commit/serve tracking, tag comparators feeding the load queue, sticky error.
module cva6_lsu_model_mq
    import cva6_lsu_model_pkg::*;
#(
    parameter int SQ_DEPTH = 4,
    parameter int LQ_DEPTH = 2,
    parameter int INSTR_W  = 32,
    parameter int ADDR_HI  = ADDR_HI_DEF,
    parameter int ADDR_LO  = ADDR_LO_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [INSTR_W-1:0]    instr_i,
    input  logic                  is_load_i,
    input  logic                  instr_valid_i,
    input  logic                  store_commit_i,
    input  logic                  store_mem_resp_i,
    input  logic                  load_mem_resp_i,
    input  logic                  flush_i,
    output logic                  load_req_o,
    output logic                  ready_o,
    output logic                  sq_full_o,
    output logic                  lq_full_o,
    output logic                  err_o,
    output logic [2*SQ_DEPTH-1:0] sq_state_o,
    output logic [2*LQ_DEPTH-1:0] lq_state_o
);

    localparam int TAG_W = ADDR_HI - ADDR_LO + 1;
    localparam int SQ_PW = ptr_w(SQ_DEPTH);

    logic             valid_q, valid_d, is_load_q, is_load_d;
    logic             commit_q, commit_d, sresp_q, sresp_d;
    logic             lresp_q, lresp_d, flush_q, flush_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    sq_state_e        sq_state_q [SQ_DEPTH];
    sq_state_e        sq_state_d [SQ_DEPTH];
    logic [TAG_W-1:0] sq_tag_q   [SQ_DEPTH];
    logic [TAG_W-1:0] sq_tag_d   [SQ_DEPTH];
    logic [SQ_PW-1:0] alloc_q, alloc_d, cptr_q, cptr_d, serve_q, serve_d;
    logic             err_q, err_d;

    logic [SQ_DEPTH-1:0]   freed, new_dep;
    logic                  store_stg, load_stg, sq_ovf, lq_ovf, store_acc, lq_alloc;
    logic                  commit_err, sresp_err, lresp_err;
    int                    sq_cnt, lq_cnt;
    lq_state_e             lq_head;
    logic [2*LQ_DEPTH-1:0] lq_state_w;
    logic                  unused_instr_bits;

    assign unused_instr_bits = ^{instr_i[INSTR_W-1:ADDR_HI+1], instr_i[ADDR_LO-1:0]};

    function automatic logic [SQ_PW-1:0] inc(input logic [SQ_PW-1:0] p);
        return (p == SQ_PW'(SQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        valid_d   = instr_valid_i;
        is_load_d = is_load_i;
        tag_d     = instr_i[ADDR_HI:ADDR_LO];
        commit_d  = store_commit_i;
        sresp_d   = store_mem_resp_i;
        lresp_d   = load_mem_resp_i;
        flush_d   = flush_i;
    end

    // Occupancy is judged on current state plus the staged instruction; a
    // flush drops the staged instruction without counting as an overflow.
    always_comb begin
        sq_cnt = 0;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            if (sq_state_q[i] != SQ_FREE) sq_cnt++;
        end
        lq_cnt = 0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (lq_state_w[2*i +: 2] != 2'd0) lq_cnt++;
        end
        store_stg = valid_q & ~is_load_q;
        load_stg  = valid_q & is_load_q;
        sq_full_o = (sq_cnt + int'(store_stg)) >= SQ_DEPTH;
        lq_full_o = (lq_cnt + int'(load_stg)) >= LQ_DEPTH;
        ready_o   = ~sq_full_o & ~lq_full_o;
        sq_ovf    = store_stg & ~flush_q & (sq_cnt == SQ_DEPTH);
        lq_ovf    = load_stg & ~flush_q & (lq_cnt == LQ_DEPTH);
        store_acc = store_stg & ~flush_q & ~sq_ovf;
        lq_alloc  = load_stg & ~flush_q & ~lq_ovf;
    end

    // Commit and serve are checked against the pre-update state, so a commit
    // and a response aimed at the same entry leave the response in error.
    always_comb begin
        sq_state_d = sq_state_q;
        sq_tag_d   = sq_tag_q;
        alloc_d    = alloc_q;
        cptr_d     = cptr_q;
        serve_d    = serve_q;
        freed      = '0;
        commit_err = 1'b0;
        sresp_err  = 1'b0;
        if (commit_q) begin
            if (sq_state_q[cptr_q] == SQ_UNCOMMITTED) begin
                sq_state_d[cptr_q] = SQ_COMMITTED;
                cptr_d             = inc(cptr_q);
            end else begin
                commit_err = 1'b1;
            end
        end
        if (sresp_q) begin
            if (sq_state_q[serve_q] == SQ_COMMITTED) begin
                sq_state_d[serve_q] = SQ_FREE;
                freed[serve_q]      = 1'b1;
                serve_d             = inc(serve_q);
            end else begin
                sresp_err = 1'b1;
            end
        end
        if (store_acc) begin
            sq_state_d[alloc_q] = SQ_UNCOMMITTED;
            sq_tag_d[alloc_q]   = tag_q;
            alloc_d             = inc(alloc_q);
        end
        if (flush_q) begin
            for (int i = 0; i < SQ_DEPTH; i++) begin
                if (sq_state_d[i] == SQ_UNCOMMITTED) begin
                    sq_state_d[i] = SQ_FREE;
                    freed[i]      = 1'b1;
                end
            end
            alloc_d = cptr_d;
        end
    end

    always_comb begin
        for (int i = 0; i < SQ_DEPTH; i++) begin
            new_dep[i] = (sq_state_q[i] != SQ_FREE) && (sq_tag_q[i] == tag_q) && !freed[i];
        end
        lresp_err = lresp_q & (lq_head != LQ_ISSUE);
        err_d     = err_q | commit_err | sresp_err | lresp_err | sq_ovf | lq_ovf;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            is_load_q <= 1'b0;
            tag_q     <= '0;
            commit_q  <= 1'b0;
            sresp_q   <= 1'b0;
            lresp_q   <= 1'b0;
            flush_q   <= 1'b0;
            for (int i = 0; i < SQ_DEPTH; i++) begin
                sq_state_q[i] <= SQ_FREE;
                sq_tag_q[i]   <= '0;
            end
            alloc_q <= '0;
            cptr_q  <= '0;
            serve_q <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            is_load_q <= is_load_d;
            tag_q     <= tag_d;
            commit_q  <= commit_d;
            sresp_q   <= sresp_d;
            lresp_q   <= lresp_d;
            flush_q   <= flush_d;
            for (int i = 0; i < SQ_DEPTH; i++) begin
                sq_state_q[i] <= sq_state_d[i];
                sq_tag_q[i]   <= sq_tag_d[i];
            end
            alloc_q <= alloc_d;
            cptr_q  <= cptr_d;
            serve_q <= serve_d;
            err_q   <= err_d;
        end
    end

    cva6_lsu_lq #(
        .LQ_DEPTH(LQ_DEPTH),
        .SQ_DEPTH(SQ_DEPTH)
    ) u_lq (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .alloc_i     (lq_alloc),
        .new_dep_i   (new_dep),
        .freed_sq_i  (freed),
        .resp_i      (lresp_q),
        .flush_i     (flush_q),
        .head_state_o(lq_head),
        .state_o     (lq_state_w)
    );

    always_comb begin
        sq_state_o = '0;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            sq_state_o[2*i +: 2] = sq_state_q[i];
        end
    end

    assign lq_state_o = lq_state_w;
    assign load_req_o = (lq_head == LQ_ISSUE);
    assign err_o      = err_q;

endmodule
